// File: rtl/sal_ddr2_sched_pkg.sv
// Shared command encoding and widths for the DDR2 command scheduler.
// Width macros normally come from SAL_DDR2_PARAMS.svh; the defaults below apply when it is absent.
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef DFI_BA_WIDTH
`define DFI_BA_WIDTH 3
`endif
`ifndef DFI_ADDR_WIDTH
`define DFI_ADDR_WIDTH 14
`endif
`ifndef DFI_CS_WIDTH
`define DFI_CS_WIDTH 1
`endif
`ifndef T_RRD_WIDTH
`define T_RRD_WIDTH 4
`endif
`ifndef T_CCD_WIDTH
`define T_CCD_WIDTH 4
`endif
`ifndef T_WTR_WIDTH
`define T_WTR_WIDTH 4
`endif
`ifndef T_RTW_WIDTH
`define T_RTW_WIDTH 4
`endif

package sal_ddr2_sched_pkg;

    localparam int RA_W    = `DRAM_RA_WIDTH;
    localparam int CA_W    = `DRAM_CA_WIDTH;
    localparam int BA_W    = `DFI_BA_WIDTH;
    localparam int ADDR_W  = `DFI_ADDR_WIDTH;
    localparam int CS_W    = `DFI_CS_WIDTH;
    localparam int T_RRD_W = `T_RRD_WIDTH;
    localparam int T_CCD_W = `T_CCD_WIDTH;
    localparam int T_WTR_W = `T_WTR_WIDTH;
    localparam int T_RTW_W = `T_RTW_WIDTH;

    localparam int A10_BIT = 10;

    typedef enum logic [2:0] {
        CMD_ACT,
        CMD_RD,
        CMD_WR,
        CMD_PRE,
        CMD_REF,
        CMD_DESEL
    } cmd_e;

    // {ras_n, cas_n, we_n}
    localparam logic [2:0] RCW_ACT   = 3'b011;
    localparam logic [2:0] RCW_RD    = 3'b101;
    localparam logic [2:0] RCW_WR    = 3'b100;
    localparam logic [2:0] RCW_PRE   = 3'b010;
    localparam logic [2:0] RCW_REF   = 3'b001;
    localparam logic [2:0] RCW_DESEL = 3'b111;

    function automatic logic [2:0] cmd_rcw(input cmd_e cmd);
        case (cmd)
            CMD_ACT: return RCW_ACT;
            CMD_RD:  return RCW_RD;
            CMD_WR:  return RCW_WR;
            CMD_PRE: return RCW_PRE;
            CMD_REF: return RCW_REF;
            default: return RCW_DESEL;
        endcase
    endfunction

endpackage

// File: rtl/sal_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among unmasked requests, searching from a
// pointer that moves past the winner whenever the caller takes the grant.
module sal_rr_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [N-1:0]  eff;
    int            idx;

    assign eff = req & ~mask;

    // NOTE: every output of a combinational block gets a default first; a
    // path that leaves one unassigned would infer a latch.
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (gnt == '0 && eff[idx]) begin
                gnt[idx] = 1'b1;
                ptr_nxt  = PW'((idx + 1) % N);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/sal_ddr2_sched.sv
// Single-rank DDR2 command scheduler: picks one REF/CAS/PRE/ACT per cycle under
// tRRD/tCCD/tWTR/tRTW and drives a registered grant plus the DFI command.
module sal_ddr2_sched
    import sal_ddr2_sched_pkg::*;
#(
    parameter int NUM_BANKS = 2 ** BA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_BANKS-1:0]      act_req,
    input  logic [NUM_BANKS-1:0]      rd_req,
    input  logic [NUM_BANKS-1:0]      wr_req,
    input  logic [NUM_BANKS-1:0]      pre_req,
    input  logic [NUM_BANKS-1:0]      ref_req,
    input  logic [NUM_BANKS*RA_W-1:0] ra,
    input  logic [NUM_BANKS*CA_W-1:0] ca,
    output logic [NUM_BANKS-1:0]      act_gnt,
    output logic [NUM_BANKS-1:0]      rd_gnt,
    output logic [NUM_BANKS-1:0]      wr_gnt,
    output logic [NUM_BANKS-1:0]      pre_gnt,
    output logic [NUM_BANKS-1:0]      ref_gnt,
    input  logic [T_RRD_W-1:0]        t_rrd,
    input  logic [T_CCD_W-1:0]        t_ccd,
    input  logic [T_WTR_W-1:0]        t_wtr,
    input  logic [T_RTW_W-1:0]        t_rtw,
    output logic                      cke,
    output logic [CS_W-1:0]           cs_n,
    output logic                      ras_n,
    output logic                      cas_n,
    output logic                      we_n,
    output logic [BA_W-1:0]           ba,
    output logic [ADDR_W-1:0]         addr,
    output logic                      odt
);

    logic [T_RRD_W-1:0]   rrd_cnt;
    logic [T_CCD_W-1:0]   ccd_cnt;
    logic [T_WTR_W-1:0]   wtr_cnt;
    logic [T_RTW_W-1:0]   rtw_cnt;
    logic                 rrd_ok, ccd_ok, wtr_ok, rtw_ok, ref_ok;
    logic [NUM_BANKS-1:0] rd_elig, wr_elig, act_elig;
    logic [NUM_BANKS-1:0] cas_pick, pre_pick, act_pick;
    logic                 cas_adv, pre_adv, act_adv;
    cmd_e                 cmd_nxt;
    logic [NUM_BANKS-1:0] gnt_nxt;
    logic [BA_W-1:0]      ba_nxt;
    logic [ADDR_W-1:0]    addr_nxt;
    logic [CS_W-1:0]      cs_nxt;

    assign rrd_ok = rrd_cnt <= T_RRD_W'(1);
    assign ccd_ok = ccd_cnt <= T_CCD_W'(1);
    assign wtr_ok = wtr_cnt <= T_WTR_W'(1);
    assign rtw_ok = rtw_cnt <= T_RTW_W'(1);

    // Timing blocks only its own class, so lower classes still see their requests.
    assign rd_elig  = (ccd_ok && wtr_ok) ? rd_req : '0;
    assign wr_elig  = (ccd_ok && rtw_ok) ? wr_req : '0;
    assign act_elig = rrd_ok ? act_req : '0;
    assign ref_ok   = (&ref_req) && !(|ref_gnt);
    assign odt      = 1'b0;

    sal_rr_arbiter #(.N(NUM_BANKS)) u_cas_arb (
        .clk(clk), .rst_n(rst_n), .req(rd_elig | wr_elig), .mask(rd_gnt | wr_gnt),
        .advance(cas_adv), .gnt(cas_pick)
    );

    sal_rr_arbiter #(.N(NUM_BANKS)) u_pre_arb (
        .clk(clk), .rst_n(rst_n), .req(pre_req), .mask(pre_gnt),
        .advance(pre_adv), .gnt(pre_pick)
    );

    sal_rr_arbiter #(.N(NUM_BANKS)) u_act_arb (
        .clk(clk), .rst_n(rst_n), .req(act_elig), .mask(act_gnt),
        .advance(act_adv), .gnt(act_pick)
    );

    function automatic logic [BA_W-1:0] onehot_idx(input logic [NUM_BANKS-1:0] oh);
        onehot_idx = '0;
        for (int i = 0; i < NUM_BANKS; i++)
            if (oh[i]) onehot_idx = BA_W'(i);
    endfunction

    always_comb begin
        cmd_nxt  = CMD_DESEL;
        gnt_nxt  = '0;
        ba_nxt   = '0;
        addr_nxt = '0;
        cas_adv  = 1'b0;
        pre_adv  = 1'b0;
        act_adv  = 1'b0;
        if (ref_ok) begin
            cmd_nxt = CMD_REF;
            gnt_nxt = '1;
        end else if (|cas_pick) begin
            cas_adv  = 1'b1;
            cmd_nxt  = (|(cas_pick & rd_elig)) ? CMD_RD : CMD_WR;
            gnt_nxt  = cas_pick;
            ba_nxt   = onehot_idx(cas_pick);
            addr_nxt = ADDR_W'(ca[ba_nxt*CA_W +: CA_W]);
            addr_nxt[A10_BIT] = 1'b0;
        end else if (|pre_pick) begin
            pre_adv = 1'b1;
            cmd_nxt = CMD_PRE;
            gnt_nxt = pre_pick;
            ba_nxt  = onehot_idx(pre_pick);
        end else if (|act_pick) begin
            act_adv  = 1'b1;
            cmd_nxt  = CMD_ACT;
            gnt_nxt  = act_pick;
            ba_nxt   = onehot_idx(act_pick);
            addr_nxt = ADDR_W'(ra[ba_nxt*RA_W +: RA_W]);
        end
        cs_nxt    = '1;
        cs_nxt[0] = (cmd_nxt == CMD_DESEL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_gnt <= '0;
            rd_gnt  <= '0;
            wr_gnt  <= '0;
            pre_gnt <= '0;
            ref_gnt <= '0;
            cke     <= 1'b0;
            cs_n    <= '1;
            {ras_n, cas_n, we_n} <= RCW_DESEL;
            ba      <= '0;
            addr    <= '0;
        end else begin
            act_gnt <= (cmd_nxt == CMD_ACT) ? gnt_nxt : '0;
            rd_gnt  <= (cmd_nxt == CMD_RD)  ? gnt_nxt : '0;
            wr_gnt  <= (cmd_nxt == CMD_WR)  ? gnt_nxt : '0;
            pre_gnt <= (cmd_nxt == CMD_PRE) ? gnt_nxt : '0;
            ref_gnt <= (cmd_nxt == CMD_REF) ? gnt_nxt : '0;
            cke     <= 1'b1;
            cs_n    <= cs_nxt;
            {ras_n, cas_n, we_n} <= cmd_rcw(cmd_nxt);
            ba      <= ba_nxt;
            addr    <= addr_nxt;
        end
    end

    // Each counter loads on its trigger and saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrd_cnt <= '0;
            ccd_cnt <= '0;
            wtr_cnt <= '0;
            rtw_cnt <= '0;
        end else begin
            rrd_cnt <= (cmd_nxt == CMD_ACT) ? t_rrd
                     : (rrd_cnt != '0) ? rrd_cnt - 1'b1 : rrd_cnt;
            ccd_cnt <= (cmd_nxt == CMD_RD || cmd_nxt == CMD_WR) ? t_ccd
                     : (ccd_cnt != '0) ? ccd_cnt - 1'b1 : ccd_cnt;
            wtr_cnt <= (cmd_nxt == CMD_WR) ? t_wtr
                     : (wtr_cnt != '0) ? wtr_cnt - 1'b1 : wtr_cnt;
            rtw_cnt <= (cmd_nxt == CMD_RD) ? t_rtw
                     : (rtw_cnt != '0) ? rtw_cnt - 1'b1 : rtw_cnt;
        end
    end

endmodule

// File: tb/tb_sal_ddr2_sched.sv
// Directed scoreboard bench for sal_ddr2_sched: expected commands with their
// issue cycle are queued by the stimulus and matched by a negedge monitor.
module tb_sal_ddr2_sched;
    import sal_ddr2_sched_pkg::*;

    localparam int NB = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NB-1:0]      act_req = '0, rd_req = '0, wr_req = '0, pre_req = '0, ref_req = '0;
    logic [NB*RA_W-1:0] ra = '0;
    logic [NB*CA_W-1:0] ca = '0;
    logic [NB-1:0]      act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic [T_RRD_W-1:0] t_rrd = '0;
    logic [T_CCD_W-1:0] t_ccd = '0;
    logic [T_WTR_W-1:0] t_wtr = '0;
    logic [T_RTW_W-1:0] t_rtw = '0;
    logic               cke;
    logic [CS_W-1:0]    cs_n;
    logic               ras_n, cas_n, we_n;
    logic [BA_W-1:0]    ba;
    logic [ADDR_W-1:0]  addr;
    logic               odt;

    sal_ddr2_sched #(.NUM_BANKS(NB)) dut (
        .clk(clk), .rst_n(rst_n),
        .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
        .ra(ra), .ca(ca),
        .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
        .t_rrd(t_rrd), .t_ccd(t_ccd), .t_wtr(t_wtr), .t_rtw(t_rtw),
        .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .ba(ba), .addr(addr), .odt(odt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string             name;
        int                at;
        logic [2:0]        rcw;
        logic [BA_W-1:0]   ba;
        logic [ADDR_W-1:0] addr;
        logic [NB-1:0]     act, rd, wr, pre, rf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   hold_rd  = 1'b0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [127:0] pack(input int at, input logic cs0, input logic [2:0] rcw,
                                          input logic [BA_W-1:0] b, input logic [ADDR_W-1:0] a,
                                          input logic [NB-1:0] g0, g1, g2, g3, g4);
        logic [15:0] at16;
        at16 = at[15:0];
        return 128'({at16, cs0, rcw, b, a, g0, g1, g2, g3, g4});
    endfunction

    function automatic logic [127:0] outs();
        return 128'({cke, cs_n[0], ras_n, cas_n, we_n, ba, addr, odt,
                     act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt});
    endfunction

    function automatic logic [127:0] desel(input logic cke_v);
        return 128'({cke_v, 1'b1, 3'b111, {BA_W{1'b0}}, {ADDR_W{1'b0}}, 1'b0, {(5*NB){1'b0}}});
    endfunction

    task automatic expect_cmd(input string name, input int at, input cmd_e cmd, input int bank,
                              input logic [ADDR_W-1:0] a);
        exp_t e;
        e.name = name;
        e.at   = at;
        e.ba   = (cmd == CMD_REF) ? '0 : BA_W'(bank);
        e.addr = a;
        e.act  = '0;
        e.rd   = '0;
        e.wr   = '0;
        e.pre  = '0;
        e.rf   = '0;
        e.rcw  = 3'b111;
        case (cmd)
            CMD_ACT: begin e.rcw = 3'b011; e.act[bank] = 1'b1; end
            CMD_RD:  begin e.rcw = 3'b101; e.rd[bank]  = 1'b1; end
            CMD_WR:  begin e.rcw = 3'b100; e.wr[bank]  = 1'b1; end
            CMD_PRE: begin e.rcw = 3'b010; e.pre[bank] = 1'b1; end
            CMD_REF: begin e.rcw = 3'b001; e.rf = '1; end
            default: ;
        endcase
        exp_q.push_back(e);
    endtask

    // Banks drop a request once they see its grant, unless holding reads on purpose.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            act_req = act_req & ~act_gnt;
            if (!hold_rd) rd_req = rd_req & ~rd_gnt;
            wr_req  = wr_req & ~wr_gnt;
            pre_req = pre_req & ~pre_gnt;
            ref_req = ref_req & ~ref_gnt;
            #1;
        end
    endtask

    task automatic set_ra(input int b, input logic [RA_W-1:0] v);
        ra[b*RA_W +: RA_W] = v;
    endtask

    task automatic set_ca(input int b, input logic [CA_W-1:0] v);
        ca[b*CA_W +: CA_W] = v;
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [127:0] got;
        got = pack(cyc, cs_n[0], {ras_n, cas_n, we_n}, ba, addr,
                   act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt);
        if (rst_n && (!cs_n[0] || (|{act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}))) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_cmd: got %0h expected no command", got);
            end else begin
                e = exp_q.pop_front();
                check(e.name, got, pack(e.at, 1'b0, e.rcw, e.ba, e.addr,
                                        e.act, e.rd, e.wr, e.pre, e.rf));
            end
        end
        while (exp_q.size() != 0 && exp_q[0].at < cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no command by cycle %0d, expected at cycle %0d", e.name, cyc, e.at);
        end
    end

    always @(negedge clk)
        if (rst_n)
            rd_wr_excl: assert (!(|(rd_req & wr_req)))
                else $error("FAIL rd_wr_same_bank: rd_req %0h wr_req %0h", rd_req, wr_req);

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected finish before 100000 ns");
        $fatal(1);
    end

    initial begin
        int c0;
        t_rrd = 4'd4;
        t_ccd = 4'd2;
        t_wtr = 4'd6;
        t_rtw = 4'd5;

        // Reset and cke release
        step(3);
        check("reset_outputs", outs(), desel(1'b0));
        rst_n = 1'b1;
        step(1);
        check("cke_rise", 128'(cke), 128'(1'b1));
        step(4);
        check("idle_deselect", outs(), desel(1'b1));

        // Two ACTs in one cycle, spaced by tRRD=4
        set_ra(0, 14'h1234);
        set_ra(1, 14'h0abc);
        act_req[1:0] = 2'b11;
        c0 = cyc;
        expect_cmd("act_b0", c0 + 1, CMD_ACT, 0, 14'h1234);
        expect_cmd("act_b1_trrd", c0 + 5, CMD_ACT, 1, 14'h0abc);
        step(20);

        // WR bank2 then RD bank3 held off by tWTR=6
        set_ca(2, 10'h155);
        set_ca(3, 10'h2aa);
        wr_req[2] = 1'b1;
        rd_req[3] = 1'b1;
        c0 = cyc;
        expect_cmd("wr_b2", c0 + 1, CMD_WR, 2, 14'h0155);
        expect_cmd("rd_b3_twtr", c0 + 7, CMD_RD, 3, 14'h02aa);
        step(20);

        // Held reads on banks 0..2 rotate, tCCD=2 apart
        hold_rd = 1'b1;
        set_ca(0, 10'h010);
        set_ca(1, 10'h011);
        set_ca(2, 10'h012);
        rd_req[2:0] = 3'b111;
        c0 = cyc;
        expect_cmd("rr_rd_b0", c0 + 1, CMD_RD, 0, 14'h0010);
        expect_cmd("rr_rd_b1", c0 + 3, CMD_RD, 1, 14'h0011);
        expect_cmd("rr_rd_b2", c0 + 5, CMD_RD, 2, 14'h0012);
        expect_cmd("rr_rd_b0_again", c0 + 7, CMD_RD, 0, 14'h0010);
        step(7);
        rd_req[2:0] = 3'b000;
        hold_rd = 1'b0;
        step(20);

        // RD bank5, WR bank6 blocked by tRTW=5, PRE bank4 fills the gap
        set_ca(5, 10'h033);
        set_ca(6, 10'h044);
        rd_req[5]  = 1'b1;
        wr_req[6]  = 1'b1;
        pre_req[4] = 1'b1;
        c0 = cyc;
        expect_cmd("rd_b5", c0 + 1, CMD_RD, 5, 14'h0033);
        expect_cmd("pre_b4_gap", c0 + 2, CMD_PRE, 4, 14'h0000);
        expect_cmd("wr_b6_trtw", c0 + 6, CMD_WR, 6, 14'h0044);
        step(20);

        // All-bank REF beats a pending RD
        ref_req = '1;
        set_ca(1, 10'h077);
        rd_req[1] = 1'b1;
        c0 = cyc;
        expect_cmd("ref_all", c0 + 1, CMD_REF, 0, 14'h0000);
        expect_cmd("rd_b1_after_ref", c0 + 2, CMD_RD, 1, 14'h0077);
        step(20);

        // Reset while an ACT grant is on the bus
        set_ra(3, 14'h0333);
        set_ra(5, 14'h0555);
        act_req[3] = 1'b1;
        act_req[5] = 1'b1;
        c0 = cyc;
        expect_cmd("act_b3_pre_reset", c0 + 1, CMD_ACT, 3, 14'h0333);
        step(1);
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), desel(1'b0));
        act_req = '0;
        step(3);
        check("cke_low_in_reset", 128'(cke), 128'(1'b0));
        rst_n = 1'b1;
        step(1);
        check("cke_rise_again", 128'(cke), 128'(1'b1));

        // Pointer restarts at 0: bank2 wins over bank5
        set_ra(2, 14'h0222);
        act_req[2] = 1'b1;
        act_req[5] = 1'b1;
        c0 = cyc;
        expect_cmd("act_b2_ptr_reset", c0 + 1, CMD_ACT, 2, 14'h0222);
        expect_cmd("act_b5_ptr_reset", c0 + 5, CMD_ACT, 5, 14'h0555);
        step(20);

        // tRRD boundaries: 1 and 0 allow back-to-back, full scale waits 15
        t_rrd = 4'd1;
        set_ra(6, 14'h0666);
        set_ra(7, 14'h0777);
        act_req[7:6] = 2'b11;
        c0 = cyc;
        expect_cmd("act_b6_trrd1", c0 + 1, CMD_ACT, 6, 14'h0666);
        expect_cmd("act_b7_trrd1", c0 + 2, CMD_ACT, 7, 14'h0777);
        step(10);

        t_rrd = 4'd0;
        set_ra(0, 14'h0100);
        set_ra(1, 14'h0101);
        act_req[1:0] = 2'b11;
        c0 = cyc;
        expect_cmd("act_b0_trrd0", c0 + 1, CMD_ACT, 0, 14'h0100);
        expect_cmd("act_b1_trrd0", c0 + 2, CMD_ACT, 1, 14'h0101);
        step(10);

        t_rrd = 4'd15;
        set_ra(2, 14'h0202);
        set_ra(3, 14'h0303);
        act_req[3:2] = 2'b11;
        c0 = cyc;
        expect_cmd("act_b2_trrd15", c0 + 1, CMD_ACT, 2, 14'h0202);
        expect_cmd("act_b3_trrd15", c0 + 16, CMD_ACT, 3, 14'h0303);
        step(25);

        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
